// File: rtl/sound_glu_pkg.sv
// Shared definitions for the sound GLU: host register map, CTRL bit
// positions and the host-transfer FSM state encoding.
package sound_glu_pkg;

  localparam int unsigned BYTE_W = 8;

  // Host register indices (host_addr)
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_DATA    = 2'd1;
  localparam logic [1:0] REG_ADDR_LO = 2'd2;
  localparam logic [1:0] REG_ADDR_HI = 2'd3;

  // CTRL bit positions; bits [3:0] are the master volume
  localparam int unsigned CTRL_VOL_MSB  = 3;
  localparam int unsigned CTRL_AUTO_INC = 5;
  localparam int unsigned CTRL_TARGET   = 6;
  localparam int unsigned CTRL_BUSY     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    INC  = 2'd3
  } state_e;

endpackage : sound_glu_pkg

// File: rtl/sound_glu_if.sv
// Host register bus of the sound GLU.
//   host_cs   : one-cycle access strobe
//   host_we   : 1 = write, 0 = read
//   host_addr : register index (CTRL, DATA, ADDR_LO, ADDR_HI)
//   host_din  : write data
//   host_dout : read data (combinational register mux)
interface sound_glu_if;
  import sound_glu_pkg::*;

  logic              host_cs;
  logic              host_we;
  logic [1:0]        host_addr;
  logic [BYTE_W-1:0] host_din;
  logic [BYTE_W-1:0] host_dout;

  modport master (output host_cs, output host_we, output host_addr,
                  output host_din, input host_dout);
  modport slave  (input host_cs, input host_we, input host_addr,
                  input host_din, output host_dout);
endinterface : sound_glu_if

// File: rtl/sound_glu_ram_arb.sv
// Sound RAM port arbiter: the DOC owns the port whenever it fetches; a
// pending host request is granted only in a cycle with doc_osc_en low.
//   host_req   : host transfer waiting for the RAM (FSM in REQ, RAM target)
//   host_we    : host transfer is a write
//   host_ptr   : host byte address
//   host_wdata : host write data
//   doc_osc_en : DOC fetch strobe
//   doc_addr   : DOC sample address
//   grant      : host owns the RAM port this cycle
//   ram_addr / ram_we / ram_din : sound RAM port
module sound_glu_ram_arb
  import sound_glu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter logic        DOC_BANK = 1'b0
) (
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_ptr,
  input  logic [BYTE_W-1:0] host_wdata,
  input  logic              doc_osc_en,
  input  logic [ADDR_W:0]   doc_addr,
  output logic              grant,
  output logic [ADDR_W:0]   ram_addr,
  output logic              ram_we,
  output logic [BYTE_W-1:0] ram_din
);

  assign grant = host_req && !doc_osc_en;

  // DOC address is the default owner of the port
  always_comb begin
    ram_addr = doc_addr;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (grant) begin
      ram_addr = {DOC_BANK, host_ptr};
      ram_we   = host_we;
      ram_din  = host_wdata;
    end
  end

endmodule : sound_glu_ram_arb

// File: rtl/sound_glu.sv
// Sound General Logic Unit: host front end for the ES5503 DOC and its
// sound RAM. Host registers CTRL/DATA/ADDR_LO/ADDR_HI; DATA accesses are
// sequenced into DOC registers or sound RAM (DOC fetches have priority).
//   CLK_14M, reset_n     : clock, async active-low reset
//   host                 : host register bus (sound_glu_if.slave)
//   doc_osc_en, doc_addr : DOC sample fetch request/address
//   doc_dout             : DOC register read data
//   doc_wr, doc_host_en, doc_reg_addr, doc_reg_din : DOC register access
//   ram_addr, ram_we, ram_din, ram_dout : sound RAM port
//   busy, volume         : status and master volume
//   host_wait            : (SOUND_GLU_STALL_EN only) high while busy
// Build option SOUND_GLU_STALL_EN: DATA accesses arriving while busy are
// queued (depth 1) instead of dropped.
module sound_glu
  import sound_glu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter logic        DOC_BANK = 1'b0
) (
  input  logic              CLK_14M,
  input  logic              reset_n,
  sound_glu_if.slave        host,
  input  logic              doc_osc_en,
  input  logic [ADDR_W:0]   doc_addr,
  input  logic [BYTE_W-1:0] doc_dout,
  output logic              doc_wr,
  output logic              doc_host_en,
  output logic [BYTE_W-1:0] doc_reg_addr,
  output logic [BYTE_W-1:0] doc_reg_din,
  output logic [ADDR_W:0]   ram_addr,
  output logic              ram_we,
  output logic [BYTE_W-1:0] ram_din,
  input  logic [BYTE_W-1:0] ram_dout,
  output logic              busy,
`ifdef SOUND_GLU_STALL_EN
  output logic              host_wait,
`endif
  output logic [3:0]        volume
);

  state_e              state_q, state_d;
  logic [6:0]          ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [BYTE_W-1:0]   latch_q, latch_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d;
  logic                op_we_q, op_we_d;
  logic                tgt_ram_q, tgt_ram_d;
  logic                busy_q;
  logic                grant_c;
  logic                data_acc_c;
`ifdef SOUND_GLU_STALL_EN
  logic                qv_q, qv_d;
  logic                q_we_q, q_we_d;
  logic [BYTE_W-1:0]   q_wdata_q, q_wdata_d;
`endif

  assign data_acc_c = host.host_cs && (host.host_addr == REG_DATA);

  sound_glu_ram_arb #(
    .ADDR_W   (ADDR_W),
    .DOC_BANK (DOC_BANK)
  ) u_ram_arb (
    .host_req   ((state_q == REQ) && tgt_ram_q),
    .host_we    (op_we_q),
    .host_ptr   (ptr_q),
    .host_wdata (wdata_q),
    .doc_osc_en (doc_osc_en),
    .doc_addr   (doc_addr),
    .grant      (grant_c),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din)
  );

  // Transfer sequencing plus host register updates
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    ptr_d     = ptr_q;
    latch_d   = latch_q;
    wdata_d   = wdata_q;
    op_we_d   = op_we_q;
    tgt_ram_d = tgt_ram_q;
`ifdef SOUND_GLU_STALL_EN
    qv_d      = qv_q;
    q_we_d    = q_we_q;
    q_wdata_d = q_wdata_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef SOUND_GLU_STALL_EN
        // A queued access goes first; target is taken from CTRL at issue
        if (qv_q) begin
          op_we_d   = q_we_q;
          wdata_d   = q_wdata_q;
          tgt_ram_d = ctrl_q[CTRL_TARGET];
          qv_d      = 1'b0;
          state_d   = REQ;
        end else
`endif
        if (data_acc_c) begin
          op_we_d   = host.host_we;
          wdata_d   = host.host_din;
          tgt_ram_d = ctrl_q[CTRL_TARGET];
          state_d   = REQ;
        end
      end
      // DOC access is a single cycle; RAM access waits for a free slot
      REQ: begin
        if (!tgt_ram_q || grant_c) begin
          state_d = op_we_q ? INC : CAP;
        end
      end
      CAP: begin
        latch_d = tgt_ram_q ? ram_dout : doc_dout;
        state_d = INC;
      end
      INC: begin
        if (ctrl_q[CTRL_AUTO_INC]) begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SOUND_GLU_STALL_EN
    // Slot is free if empty, or if it is being issued this very cycle
    if (data_acc_c && (((state_q != IDLE) && !qv_q) || ((state_q == IDLE) && qv_q))) begin
      qv_d      = 1'b1;
      q_we_d    = host.host_we;
      q_wdata_d = host.host_din;
    end
`endif

    // Host register writes override the auto-increment
    if (host.host_cs && host.host_we) begin
      case (host.host_addr)
        REG_CTRL:    ctrl_d      = host.host_din[6:0];
        REG_ADDR_LO: ptr_d[7:0]  = host.host_din;
        REG_ADDR_HI: ptr_d[15:8] = host.host_din;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      ptr_q     <= '0;
      latch_q   <= '0;
      wdata_q   <= '0;
      op_we_q   <= 1'b0;
      tgt_ram_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SOUND_GLU_STALL_EN
      qv_q      <= 1'b0;
      q_we_q    <= 1'b0;
      q_wdata_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      ptr_q     <= ptr_d;
      latch_q   <= latch_d;
      wdata_q   <= wdata_d;
      op_we_q   <= op_we_d;
      tgt_ram_q <= tgt_ram_d;
      busy_q    <= (state_d != IDLE);
`ifdef SOUND_GLU_STALL_EN
      qv_q      <= qv_d;
      q_we_q    <= q_we_d;
      q_wdata_q <= q_wdata_d;
`endif
    end
  end

  // DOC register access strobes for the single REQ cycle
  assign doc_host_en  = (state_q == REQ) && !tgt_ram_q;
  assign doc_wr       = (state_q == REQ) && !tgt_ram_q && op_we_q;
  assign doc_reg_addr = ptr_q[7:0];
  assign doc_reg_din  = wdata_q;

  assign busy   = busy_q;
  assign volume = ctrl_q[CTRL_VOL_MSB:0];
`ifdef SOUND_GLU_STALL_EN
  assign host_wait = busy_q;
`endif

  // Host read mux
  always_comb begin
    case (host.host_addr)
      REG_CTRL:    host.host_dout = {busy_q, ctrl_q};
      REG_DATA:    host.host_dout = latch_q;
      REG_ADDR_LO: host.host_dout = ptr_q[7:0];
      REG_ADDR_HI: host.host_dout = ptr_q[15:8];
      default:     host.host_dout = '0;
    endcase
  end

endmodule : sound_glu
